// File: rtl/sr_pkg.sv
// Shared types and helpers for the PISO serializer.
// Defining SR_PISO_CTRL_PARITY_EN adds the PARITY state (even-parity bit after each word).
package sr_pkg;

`ifdef SR_PISO_CTRL_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity} piso_state_e;
`else
    typedef enum logic [0:0] {StIdle, StShift} piso_state_e;
`endif

    // Ceil log2, floored at 1 so the counter always has at least one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        int unsigned w;
        w = 1;
        while ((1 << w) < width) w++;
        return w;
    endfunction

endpackage

// File: rtl/sr_piso_shifter.sv
// Left-shifting register for the PISO serializer; msb is the bit currently on the wire.
module sr_piso_shifter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);

    logic [WIDTH-1:0] sr_q;

    // Zero fill means the register drains to 0 once a word is fully emitted.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= d;
        end else if (shift) begin
            sr_q <= {sr_q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/sr_piso_ctrl.sv
// Parallel-in serial-out controller: MSB-first, back-to-back streaming without bubbles.
// Define SR_PISO_CTRL_PARITY_EN to append an even-parity bit to each word.
module sr_piso_ctrl
    import sr_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CntMax = CW'(WIDTH - 1);

    piso_state_e      state_q;
    logic [CW-1:0]    cnt_q;
    logic             ser_valid_q;
    logic             ser_last_q;
    logic             last_bit;
    logic             accept;
    logic             sh_load;
    logic             sh_shift;
    logic [WIDTH-1:0] sh_d;

    assign last_bit = (state_q == StShift) && (cnt_q == '0);
    assign accept   = in_valid && in_ready;

`ifdef SR_PISO_CTRL_PARITY_EN
    logic parity_q;

    assign in_ready = (state_q == StIdle) || (state_q == StParity);
    // The parity bit rides through the shifter so ser_out stays a flop output.
    assign sh_load  = accept || last_bit;
    assign sh_d     = accept ? in_data : {parity_q, {(WIDTH-1){1'b0}}};
`else
    assign in_ready = (state_q == StIdle) || last_bit;
    assign sh_load  = accept;
    assign sh_d     = in_data;
`endif

    assign sh_shift = (state_q != StIdle) && !sh_load;
    assign busy      = (state_q != StIdle);
    assign ser_valid = ser_valid_q;
    assign ser_last  = ser_last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
`ifdef SR_PISO_CTRL_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else if (accept) begin
            state_q     <= StShift;
            cnt_q       <= CntMax;
            ser_valid_q <= 1'b1;
            ser_last_q  <= 1'b0;
`ifdef SR_PISO_CTRL_PARITY_EN
            parity_q    <= ^in_data;
`endif
        end else begin
            case (state_q)
                StShift: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
`ifdef SR_PISO_CTRL_PARITY_EN
                        ser_last_q <= 1'b0;
`else
                        ser_last_q <= (cnt_q == CW'(1));
`endif
                    end else begin
`ifdef SR_PISO_CTRL_PARITY_EN
                        state_q    <= StParity;
                        ser_last_q <= 1'b1;
`else
                        state_q     <= StIdle;
                        ser_valid_q <= 1'b0;
                        ser_last_q  <= 1'b0;
`endif
                    end
                end
`ifdef SR_PISO_CTRL_PARITY_EN
                StParity: begin
                    state_q     <= StIdle;
                    ser_valid_q <= 1'b0;
                    ser_last_q  <= 1'b0;
                end
`endif
                default: begin
                    state_q     <= StIdle;
                    ser_valid_q <= 1'b0;
                    ser_last_q  <= 1'b0;
                end
            endcase
        end
    end

    sr_piso_shifter #(
        .WIDTH(WIDTH)
    ) u_shifter (
        .clk  (clk),
        .reset(reset),
        .load (sh_load),
        .shift(sh_shift),
        .d    (sh_d),
        .msb  (ser_out)
    );

endmodule

// File: tb/tb_sr_piso_ctrl.sv
// Self-checking bench for sr_piso_ctrl: beat-queue reference model plus directed WIDTH=8 case.
module tb_sr_piso_ctrl;

`ifdef SR_PISO_CTRL_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready, ser_out, ser_valid, ser_last, busy;

    logic [7:0] in_data8 = '0;
    logic       in_valid8 = 1'b0;
    logic       in_ready8, ser_out8, ser_valid8, ser_last8, busy8;

    logic [4:0] act;
    assign act = {ser_valid, ser_out, ser_last, busy, in_ready};

    typedef struct packed {
        logic b;
        logic last;
    } beat_t;

    beat_t q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    sr_piso_ctrl #(.WIDTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ser_out  (ser_out),
        .ser_valid(ser_valid),
        .ser_last (ser_last),
        .busy     (busy)
    );

    sr_piso_ctrl #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data8),
        .in_valid (in_valid8),
        .in_ready (in_ready8),
        .ser_out  (ser_out8),
        .ser_valid(ser_valid8),
        .ser_last (ser_last8),
        .busy     (busy8)
    );

    // Expected {ser_valid, ser_out, ser_last, busy, in_ready}; head of q is the beat on the wire.
    function automatic logic [4:0] exp_vec();
        if (q.size() == 0) return 5'b00001;
        return {1'b1, q[0].b, q[0].last, 1'b1, q.size() <= 1};
    endfunction

    task automatic push_word(input logic [3:0] d);
        for (int i = 3; i >= 0; i--) q.push_back(beat_t'{b: d[i], last: (i == 0) && !PAR});
        if (PAR) q.push_back(beat_t'{b: ^d, last: 1'b1});
    endtask

    // Advance one clock and update the model with the inputs seen at that edge.
    task automatic tick();
        logic acc;
        @(posedge clk);
        if (reset) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() <= 1);
            if (q.size() > 0) void'(q.pop_front());
            if (acc) push_word(in_data);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 4'hF;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++;
            if (act !== 5'b00001) begin
                n_err++;
                $display("FAIL reset4 got=%b exp=00001", act);
            end
            n_cmp++;
            if ({ser_valid8, ser_out8, ser_last8, busy8, in_ready8} !== 5'b00001) begin
                n_err++;
                $display("FAIL reset8 got=%b exp=00001",
                         {ser_valid8, ser_out8, ser_last8, busy8, in_ready8});
            end
        end
        reset = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_single();
        in_data = 4'b1011;
        in_valid = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            in_valid = 1'b0;
            n_cmp++;
            if (act !== exp_vec()) begin
                n_err++;
                $display("FAIL single cyc=%0d got=%b exp=%b", c, act, exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] words[2];
        int idx = 0;
        int run = 0;
        bit gap = 0;
        bit rdy;
        words[0] = 4'hA;
        words[1] = 4'h5;
        for (int c = 1; c <= 14; c++) begin
            in_valid = (idx < 2);
            if (idx < 2) in_data = words[idx];
            rdy = (q.size() <= 1);
            tick();
            if (rdy && idx < 2) idx++;
            n_cmp++;
            if (act !== exp_vec()) begin
                n_err++;
                $display("FAIL b2b cyc=%0d got=%b exp=%b", c, act, exp_vec());
            end
            if (ser_valid && !gap) run++;
            else if (run > 0) gap = 1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (run !== 2 * (4 + int'(PAR))) begin
            n_err++;
            $display("FAIL b2b_run got=%0d exp=%0d", run, 2 * (4 + int'(PAR)));
        end
    endtask

    task automatic test_ignore();
        in_data = 4'h6;
        in_valid = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            in_valid = 1'b0;
            if (c == 2) begin
                in_valid = 1'b1;
                in_data = 4'($urandom);
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL ignore_ready got=%b exp=0", in_ready);
                end
            end
            n_cmp++;
            if (act !== exp_vec()) begin
                n_err++;
                $display("FAIL ignore cyc=%0d got=%b exp=%b", c, act, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        in_data = 4'hF;
        in_valid = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            tick();
            in_valid = 1'b0;
            n_cmp++;
            if (act !== exp_vec()) begin
                n_err++;
                $display("FAIL rstmid cyc=%0d got=%b exp=%b", c, act, exp_vec());
            end
        end
        reset = 1'b1;
        in_valid = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if ({ser_valid, busy, in_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL rstmid_after got=%b exp=001", {ser_valid, busy, in_ready});
        end
        tick();
        n_cmp++;
        if (act !== exp_vec()) begin
            n_err++;
            $display("FAIL rstmid_idle got=%b exp=%b", act, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_data = 4'($urandom);
            tick();
            n_cmp++;
            if (act !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc=%0d got=%b exp=%b", c, act, exp_vec());
            end
        end
        reset = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 12; c++) tick();
        n_cmp++;
        if (act !== 5'b00001) begin
            n_err++;
            $display("FAIL random_drain got=%b exp=00001", act);
        end
    endtask

    task automatic test_width8();
        logic [7:0] w;
        w = 8'h81;
        in_data8 = w;
        in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            n_cmp++;
            if ({ser_valid8, ser_out8, ser_last8} !== {1'b1, w[8-k], (k == 8) && !PAR}) begin
                n_err++;
                $display("FAIL w8 bit=%0d got=%b exp=%b", k, {ser_valid8, ser_out8, ser_last8},
                         {1'b1, w[8-k], (k == 8) && !PAR});
            end
            n_cmp++;
            if ((dut8.cnt_q == '0) !== (k == 8)) begin
                n_err++;
                $display("FAIL w8_cnt bit=%0d got=%0d exp_zero=%0d", k, dut8.cnt_q, k == 8);
            end
            tick();
        end
`ifdef SR_PISO_CTRL_PARITY_EN
        n_cmp++;
        if ({ser_valid8, ser_out8, ser_last8, in_ready8} !== {1'b1, ^w, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL w8_parity got=%b exp=%b", {ser_valid8, ser_out8, ser_last8, in_ready8},
                     {1'b1, ^w, 1'b1, 1'b1});
        end
        tick();
`endif
        n_cmp++;
        if ({ser_valid8, ser_out8, ser_last8, busy8, in_ready8} !== 5'b00001) begin
            n_err++;
            $display("FAIL w8_idle got=%b exp=00001",
                     {ser_valid8, ser_out8, ser_last8, busy8, in_ready8});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        test_random();
        test_width8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sr_piso_ctrl.md
SR_PISO_CTRL -- requirements
Module: sr_piso_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_data, input, WIDTH bits: the parallel word to serialize.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a word; a transfer occurs when in_valid and in_ready are both high on the same edge.
REQ-007 SHALL have port ser_out, output, 1 bit: the serial data bit.
REQ-008 SHALL have port ser_valid, output, 1 bit: ser_out carries a valid bit this cycle.
REQ-009 SHALL have port ser_last, output, 1 bit: high on the final bit of a word.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, SHIFT and PARITY, with PARITY present only under the macro of REQ-024.
REQ-012 SHALL, in IDLE, drive in_ready=1, ser_valid=0, ser_out=0 and ser_last=0.
REQ-013 SHALL, on a transfer, capture in_data into the shift register, load the bit counter with WIDTH-1, and enter SHIFT on the next cycle.
REQ-014 SHALL emit bits MSB-first: in_data[WIDTH-1] appears on ser_out the cycle after the transfer, and one bit follows per cycle for WIDTH consecutive cycles with ser_valid=1 throughout.
REQ-015 SHALL register ser_out, ser_valid and ser_last, with no combinational path from in_data or in_valid to any of them.
REQ-016 SHALL decrement the counter once per SHIFT cycle and treat counter==0 as the last data bit.
REQ-017 SHALL assert ser_last on the last data bit (or on the parity bit per REQ-025) and at no other time.
REQ-018 SHALL drive in_ready=1 during the final emitted bit cycle, so that back-to-back words stream with zero bubble cycles.
REQ-019 SHALL, on a transfer during the final bit cycle, reload from in_data and remain in SHIFT; otherwise it SHALL return to IDLE.
REQ-020 SHALL keep in_ready=0 on every non-final SHIFT cycle and ignore in_valid during those cycles.
REQ-021 SHALL keep ser_out=0 whenever ser_valid=0.

Reset
REQ-022 SHALL, while reset is high at a clock edge, force the state to IDLE, the shift register and counter to 0, and ser_out, ser_valid, ser_last and busy to 0.
REQ-023 SHALL, on reset asserted mid-word, abandon the word without emitting further bits, and SHALL ignore in_valid during the reset cycle.

Configuration
REQ-024 SHALL define the macro SR_PISO_CTRL_PARITY_EN; when it is defined, a PARITY state follows the last data bit of every word.
REQ-025 SHALL, with SR_PISO_CTRL_PARITY_EN defined, emit one extra bit per word equal to the XOR of the word's data bits (even parity), with ser_valid=1 and ser_last=1 on that bit, ser_last=0 on the last data bit, and in_ready=1 only in PARITY, giving WIDTH+1 cycles per word.
REQ-026 SHALL, without SR_PISO_CTRL_PARITY_EN, have no parity logic or PARITY state and take exactly WIDTH cycles per word.

Structure
REQ-027 SHALL place the state enumeration typedef and the counter-width helper (ceil log2 of WIDTH) in the shared package sr_pkg.
REQ-028 SHALL instantiate the shift register as a sub-module sr_piso_shifter with inputs load, shift and d[WIDTH] and an MSB output; the FSM and counter SHALL stay in sr_piso_ctrl.

Verification
REQ-029 SHALL cover: WIDTH=4, no macro, one transfer of 4'b1011 at cycle 0 -> ser_out 1,0,1,1 on cycles 1-4, ser_last on cycle 4, busy cycles 1-4, IDLE at cycle 5.
REQ-030 SHALL cover: in_valid held high with words 4'hA then 4'h5 -> 8 contiguous valid bits 1,0,1,0,0,1,0,1, ser_last on bits 4 and 8, no bubble.
REQ-031 SHALL cover: in_valid pulsed during cycle 2 of a word -> in_ready=0, word ignored, and the serial stream unchanged.
REQ-032 SHALL cover: reset asserted on cycle 2 of 4'hF -> ser_valid=0 from cycle 3, IDLE, and in_ready=1 on the first cycle after reset deasserts.
REQ-033 SHALL cover: with SR_PISO_CTRL_PARITY_EN, word 4'b0111 -> bits 0,1,1,1 then parity 1, ser_last only on cycle 5, in_ready only on cycle 5.
REQ-034 SHALL cover: WIDTH=8, word 8'h81 -> 1,0,0,0,0,0,0,1, with the counter reaching 0 exactly on the 8th bit.
